motor_cmd_scheduler: RTL and testbench

Shares the robot-base UART link between several command requesters and serialises the winning command as a fixed-length 26-byte JSON frame into the existing `uart_tx` byte transmitter. Arbitration between requesters is round-robin. The block also re-sends the last command periodically, because the base drops to idle without traffic. It sits between the motion-decision logic (navigation, obstacle, manual override) and `uart_tx`, and replaces per-command hard-coded frame senders.

---
 rtl/motor_cmd_scheduler.sv | 167 ++++++++++++++++
 tb/tb_motor_cmd_scheduler.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_cmd_scheduler.sv
// motor_cmd_scheduler: round-robin arbiter that serialises 26-byte JSON
// motion frames into uart_tx and re-sends the last command when idle.
module motor_cmd_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int REFRESH_CLKS = 25_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [2*NUM_REQ-1:0] req_cmd,
  output logic [NUM_REQ-1:0]   grant,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic [1:0]           last_cmd,
  output logic                 frame_done
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = (REFRESH_CLKS > 1) ? $clog2(REFRESH_CLKS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_CLKS - 1);
  localparam logic [4:0] LAST_IDX = 5'd25;

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_e;

  state_e        state_q;
  logic [1:0]    cmd_q;
  logic [PW-1:0] rr_ptr_q;
  logic [4:0]    byte_idx_q;
  logic [CW-1:0] refresh_cnt_q;
  logic [7:0]    tx_data_q;
  logic          tx_valid_q;
  logic          frame_done_q;

  logic          found;
  logic [PW-1:0] winner;
  logic [PW-1:0] rr_ptr_d;
  logic [1:0]    win_cmd;

  // Descending scan so the requester closest to rr_ptr is written last.
  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (req[idx]) begin
        found  = 1'b1;
        winner = PW'(idx);
      end
    end
    win_cmd  = req_cmd[2*int'(winner) +: 2];
    rr_ptr_d = PW'((int'(winner) + 1) % NUM_REQ);
  end

  always_comb begin
    grant = '0;
    if (!rst && state_q == IDLE && found)
      grant[winner] = 1'b1;
  end

  function automatic logic [7:0] frame_byte(
    input logic [4:0] idx,
    input logic [1:0] cmd
  );
    logic [31:0] l;
    logic [31:0] r;
    logic [7:0]  b;
    unique case (cmd)
      2'd0: begin l = "0.00"; r = "0.00"; end
      2'd1: begin l = "0.50"; r = "0.50"; end
      2'd2: begin l = "-0.3"; r = "0.30"; end
      2'd3: begin l = "0.30"; r = "-0.3"; end
    endcase
    case (idx)
      5'd0:    b = "{";
      5'd1:    b = "\"";
      5'd2:    b = "T";
      5'd3:    b = "\"";
      5'd4:    b = ":";
      5'd5:    b = "1";
      5'd6:    b = ",";
      5'd7:    b = "\"";
      5'd8:    b = "L";
      5'd9:    b = "\"";
      5'd10:   b = ":";
      5'd11:   b = l[31:24];
      5'd12:   b = l[23:16];
      5'd13:   b = l[15:8];
      5'd14:   b = l[7:0];
      5'd15:   b = ",";
      5'd16:   b = "\"";
      5'd17:   b = "R";
      5'd18:   b = "\"";
      5'd19:   b = ":";
      5'd20:   b = r[31:24];
      5'd21:   b = r[23:16];
      5'd22:   b = r[15:8];
      5'd23:   b = r[7:0];
      5'd24:   b = "}";
      5'd25:   b = 8'h0A;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cmd_q         <= 2'd0;
      rr_ptr_q      <= '0;
      byte_idx_q    <= '0;
      refresh_cnt_q <= CNT_MAX;
      tx_data_q     <= 8'h00;
      tx_valid_q    <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (refresh_cnt_q != CNT_MAX)
            refresh_cnt_q <= refresh_cnt_q + CW'(1);
          if (found) begin
            cmd_q      <= win_cmd;
            rr_ptr_q   <= rr_ptr_d;
            byte_idx_q <= '0;
            tx_data_q  <= frame_byte(5'd0, win_cmd);
            tx_valid_q <= 1'b1;
            state_q    <= SEND;
          end else if (refresh_cnt_q == CNT_MAX) begin
            byte_idx_q <= '0;
            tx_data_q  <= frame_byte(5'd0, cmd_q);
            tx_valid_q <= 1'b1;
            state_q    <= SEND;
          end
        end
        SEND: begin
          if (tx_valid_q && tx_ready) begin
            if (byte_idx_q == LAST_IDX) begin
              tx_valid_q   <= 1'b0;
              tx_data_q    <= 8'h00;
              frame_done_q <= 1'b1;
              state_q      <= DONE;
            end else begin
              byte_idx_q <= byte_idx_q + 5'd1;
              tx_data_q  <= frame_byte(byte_idx_q + 5'd1, cmd_q);
            end
          end
        end
        DONE: begin
          refresh_cnt_q <= '0;
          state_q       <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != IDLE);
  assign last_cmd   = cmd_q;

endmodule

// File: tb/tb_motor_cmd_scheduler.sv
// tb_motor_cmd_scheduler: frame/grant scoreboard bench for
// motor_cmd_scheduler with a small table of arbitration vectors.
module tb_motor_cmd_scheduler;

  localparam int NREQ = 4;
  localparam int RCLK = 16;

  logic            clk;
  logic            rst;
  logic [NREQ-1:0] req;
  logic [7:0]      req_cmd;
  logic [NREQ-1:0] grant;
  logic [7:0]      tx_data;
  logic            tx_valid;
  logic            tx_ready;
  logic            busy;
  logic [1:0]      last_cmd;
  logic            frame_done;

  motor_cmd_scheduler #(
    .NUM_REQ(NREQ),
    .REFRESH_CLKS(RCLK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_cmd(req_cmd),
    .grant(grant),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .busy(busy),
    .last_cmd(last_cmd),
    .frame_done(frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0] rq;
    logic [7:0] cmds;
    logic [3:0] g;
    int         c;
  } vec_t;

  logic [7:0] bq[$];
  logic [3:0] gq[$];
  int   checks;
  int   failures;
  int   acc;
  bit   rnd;
  bit   saw_done;
  bit   saw_grant;
  bit   v_neg;
  bit   pv_valid;
  bit   pv_ready;
  logic [7:0] pv_data;

  task automatic check(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic string frame_str(int c);
    string l;
    string r;
    case (c)
      0:       begin l = "0.00"; r = "0.00"; end
      1:       begin l = "0.50"; r = "0.50"; end
      2:       begin l = "-0.3"; r = "0.30"; end
      default: begin l = "0.30"; r = "-0.3"; end
    endcase
    return {"{\"T\":1,\"L\":", l, ",\"R\":", r, "}\n"};
  endfunction

  task automatic push_frame(int c);
    string s;
    s = frame_str(c);
    for (int i = 0; i < s.len(); i++)
      bq.push_back(s[i]);
  endtask

  // One clock: monitor at negedge, then drive tx_ready after posedge.
  task automatic cyc();
    @(negedge clk);
    v_neg = 1'b0;
    if (rst) begin
      bq.delete();
      gq.delete();
      acc      = 0;
      pv_valid = 1'b0;
    end else begin
      v_neg = tx_valid;
      if (grant != '0) begin
        saw_grant = 1'b1;
        check("grant_onehot", $countones(grant), 1);
        if (gq.size() == 0)
          check("grant_unexpected", int'(grant), 0);
        else
          check("grant", int'(grant), int'(gq.pop_front()));
      end
      if (pv_valid && !pv_ready) begin
        check("hold_valid", int'(tx_valid), 1);
        check("hold_data", int'(tx_data), int'(pv_data));
      end
      if (tx_valid && tx_ready) begin
        if (bq.size() == 0)
          check("byte_unexpected", int'(tx_data), -1);
        else
          check("tx_byte", int'(tx_data), int'(bq.pop_front()));
        acc++;
      end
      if (frame_done) begin
        saw_done = 1'b1;
        check("frame_len", acc, 26);
        acc = 0;
      end
      pv_valid = tx_valid;
      pv_ready = tx_ready;
      pv_data  = tx_data;
    end
    @(posedge clk);
    #1;
    tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic wait_done(string nm, int limit);
    int n;
    n = 0;
    saw_done = 1'b0;
    while (!saw_done && n < limit) begin
      cyc();
      n++;
    end
    if (!saw_done) check({nm, "_done_timeout"}, 0, 1);
  endtask

  task automatic wait_grant(string nm, int limit, output int n);
    n = 0;
    saw_grant = 1'b0;
    while (!saw_grant && n < limit) begin
      cyc();
      n++;
    end
    if (!saw_grant) check({nm, "_grant_timeout"}, 0, 1);
  endtask

  initial begin
    vec_t tbl[6];
    int   n;
    logic [1:0] cc;

    tbl[0] = '{4'b0101, 8'b0010_0001, 4'b0001, 1};
    tbl[1] = '{4'b0101, 8'b0010_0001, 4'b0100, 2};
    tbl[2] = '{4'b0101, 8'b0010_0001, 4'b0001, 1};
    tbl[3] = '{4'b0110, 8'b0010_0000, 4'b0010, 0};
    tbl[4] = '{4'b1001, 8'b1100_0001, 4'b1000, 3};
    tbl[5] = '{4'b1001, 8'b1100_0001, 4'b0001, 1};

    checks   = 0;
    failures = 0;
    acc      = 0;
    rnd      = 1'b0;
    pv_valid = 1'b0;
    pv_ready = 1'b0;
    pv_data  = 8'h00;
    rst      = 1'b1;
    req      = '0;
    req_cmd  = '0;
    tx_ready = 1'b1;

    cyc();
    cyc();
    check("rst_grant", int'(grant), 0);
    check("rst_valid", int'(tx_valid), 0);
    check("rst_data", int'(tx_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(frame_done), 0);
    check("rst_last_cmd", int'(last_cmd), 0);

    rst = 1'b0;
    push_frame(0);
    wait_done("boot_stop", 100);
    check("boot_last_cmd", int'(last_cmd), 0);

    push_frame(0);
    n = 0;
    v_neg = 1'b0;
    while (!v_neg && n < 100) begin
      cyc();
      n++;
    end
    check("refresh_gap", n, RCLK + 1);
    wait_done("refresh", 100);

    foreach (tbl[i]) begin
      req     = tbl[i].rq;
      req_cmd = tbl[i].cmds;
      gq.push_back(tbl[i].g);
      push_frame(tbl[i].c);
      wait_grant("tbl", 50, n);
      req = '0;
      wait_done("tbl", 200);
      check("tbl_last_cmd", int'(last_cmd), tbl[i].c);
    end

    rnd = 1'b1;
    for (int c = 3; c >= 0; c--) begin
      cc      = 2'(c);
      req     = 4'(1 << c);
      req_cmd = {4{cc}};
      gq.push_back(4'(1 << c));
      push_frame(c);
      wait_grant("rand", 50, n);
      req = '0;
      wait_done("rand", 400);
    end
    rnd      = 1'b0;
    tx_ready = 1'b1;

    push_frame(0);
    n = 0;
    v_neg = 1'b0;
    while (!v_neg && n < 40) begin
      cyc();
      n++;
    end
    check("refresh_start", int'(v_neg), 1);
    req     = 4'b1000;
    req_cmd = 8'b1100_0000;
    gq.push_back(4'b1000);
    push_frame(3);
    wait_done("refresh_pend", 100);
    wait_grant("pend", 10, n);
    check("pend_grant_delay", n, 1);
    req = '0;
    wait_done("pend_right", 100);
    check("pend_last_cmd", int'(last_cmd), 3);

    req     = 4'b0010;
    req_cmd = 8'b0000_0100;
    gq.push_back(4'b0010);
    push_frame(1);
    wait_grant("mid", 50, n);
    req = '0;
    n = 0;
    while (acc != 12 && n < 100) begin
      cyc();
      n++;
    end
    check("reach_byte12", acc, 12);
    rst = 1'b1;
    cyc();
    check("midrst_valid", int'(tx_valid), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_last_cmd", int'(last_cmd), 0);
    rst = 1'b0;
    push_frame(0);
    wait_done("post_rst", 100);
    check("post_rst_last_cmd", int'(last_cmd), 0);
    check("queue_empty", bq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
